mul_div_unit: RTL
=================

// Module: mul_div_unit
// PURPOSE
//  Iterative unsigned 16-bit multiply/divide unit in the execute/writeback path.
//  Consumes the two register-file read operands, computes over multiple cycles,
//  then drives the register-file write port (wr_en/dest/data) for one cycle.
//  The core stalls on busy; results are written back without a separate mux stage.
// PARAMETERS
//  WIDTH   16  operand/result width; iteration count = WIDTH
//  ADDR_W  3   register address width (8 registers)
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous, active-high reset
//  start        in   1       request; sampled only in IDLE
//  op           in   2       00 MUL (low WIDTH bits), 01 DIV quotient, 10 REM (macro), 11 reserved
//  src_a        in   WIDTH   multiplicand / dividend
//  src_b        in   WIDTH   multiplier / divisor
//  dest         in   ADDR_W  destination register, captured with start
//  busy         out  1       high from cycle after accept until WB cycle inclusive
//  done         out  1       one-cycle pulse in WB cycle
//  div_by_zero  out  1       sticky until next accepted start; set on DIV/REM with src_b==0
//  reg_wr_en    out  1       one-cycle write strobe to register file (WB cycle)
//  reg_wr_dest  out  ADDR_W  write address, valid while reg_wr_en
//  reg_wr_data  out  WIDTH   write data, valid while reg_wr_en
// BEHAVIOUR
//  - Reset (any cycle, incl. mid-operation): state=IDLE, all outputs 0, counter 0,
//    internal operand/accumulator registers 0; aborted operation never writes back.
//  - FSM: IDLE -> RUN on start (op!=11); IDLE -> WB directly for DIV/REM with src_b==0;
//    RUN -> WB when iteration counter reaches WIDTH-1; WB -> IDLE unconditionally.
//  - start with op==11 (or op==10 without macro): ignored, stays IDLE, no write.
//  - start while busy: ignored; operands/dest not recaptured.
//  - Accept cycle = cycle 0 (operands, op, dest latched). RUN occupies cycles 1..WIDTH.
//    WB at cycle WIDTH+1: reg_wr_en=1, done=1, data/dest driven. Next start accepted
//    earliest at cycle WIDTH+2 (IDLE). Div-by-zero: WB at cycle 1.
//  - MUL: shift-add, one multiplier bit per cycle, LSB first; 2*WIDTH accumulator,
//    result = low WIDTH bits (overflow silently truncated, no flag).
//  - DIV/REM: restoring division, one quotient bit per cycle, MSB first;
//    WIDTH+1-bit partial remainder to hold the subtract borrow.
//  - Divide by zero: quotient = all ones, remainder = src_a, div_by_zero=1.
//  - reg_wr_data/reg_wr_dest are 0 whenever reg_wr_en=0.
//  - div_by_zero cleared on every accepted start; otherwise holds.
// CONFIGURATION
//  MULDIV_REM_EN defined: op=10 accepted, writes remainder (same latency as DIV).
//  MULDIV_REM_EN undefined: op=10 treated as reserved (ignored, no write);
//    remainder logic still exists internally only as needed for DIV.
// TESTING
//  1. 7*6, op=00, dest=3 -> reg_wr_en at cycle 17, dest=3, data=0x002A, done pulse 1 cycle.
//  2. 0xFFFF*0xFFFF, op=00 -> data=0x0001 (truncated), div_by_zero=0.
//  3. 100/7 op=01 -> 0x000E; with MULDIV_REM_EN op=10 -> 0x0002; without macro op=10 -> no write, busy stays 0.
//  4. 5/0 op=01 -> WB at cycle 1, data=0xFFFF, div_by_zero=1; next accepted start clears flag.
//  5. start pulsed at cycle 5 during busy MUL with different operands/dest -> only original result written, one write total.
//  6. rst asserted at cycle 8 of a DIV -> next cycle busy=0, no reg_wr_en ever; fresh start then completes normally.

Source files
------------

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
// Iterative unsigned multiply / divide unit sitting in the execute/writeback
// path. It latches two register-file operands on start, iterates one bit per
// cycle for WIDTH cycles, then drives the register-file write port for exactly
// one cycle. The core is expected to stall while busy is high.
//
// Optional feature macro: MULDIV_REM_EN
//   defined   -> op=10 (REM) is accepted and writes the remainder
//   undefined -> op=10 is treated like the reserved op=11 (ignored)
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   start        in   request, sampled only in IDLE
//   op[1:0]      in   00 MUL, 01 DIV quotient, 10 REM, 11 reserved
//   src_a        in   multiplicand / dividend
//   src_b        in   multiplier / divisor
//   dest         in   destination register, captured with start
//   busy         out  high from the cycle after accept through the WB cycle
//   done         out  one-cycle pulse in the WB cycle
//   div_by_zero  out  sticky flag, cleared on every accepted start
//   reg_wr_en    out  one-cycle register-file write strobe
//   reg_wr_dest  out  write address, zero unless reg_wr_en
//   reg_wr_data  out  write data, zero unless reg_wr_en
// ---------------------------------------------------------------------------
module mul_div_unit #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  src_a,
    input  logic [WIDTH-1:0]  src_b,
    input  logic [ADDR_W-1:0] dest,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic              reg_wr_en,
    output logic [ADDR_W-1:0] reg_wr_dest,
    output logic [WIDTH-1:0]  reg_wr_data
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_DIV = 2'b01;
`ifdef MULDIV_REM_EN
    localparam logic [1:0] OP_REM = 2'b10;
`endif

    typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [1:0]          op_r;
    logic [ADDR_W-1:0]   dest_r;
    // a_r: dividend shifting out MSB-first while quotient bits shift in.
    // b_r: multiplier (shifted right, LSB first) or divisor (held).
    logic [WIDTH-1:0]    a_r;
    logic [WIDTH-1:0]    b_r;
    logic [2*WIDTH-1:0]  mcand;
    logic [2*WIDTH-1:0]  acc;
    // One extra bit so the trial subtract's borrow lands in the MSB.
    logic [WIDTH:0]      prem;

    logic                op_ok;
    logic [2*WIDTH-1:0]  acc_nx;
    logic [WIDTH:0]      shifted;
    logic [WIDTH:0]      diff;
    logic [WIDTH:0]      prem_nx;
    logic [WIDTH-1:0]    a_nx;

    always_comb begin
        op_ok = (op == OP_MUL) || (op == OP_DIV)
`ifdef MULDIV_REM_EN
                || (op == OP_REM)
`endif
                ;
    end

    // One iteration of each datapath; only the one matching op_r is committed.
    always_comb begin
        acc_nx  = b_r[0] ? (acc + mcand) : acc;
        shifted = {prem[WIDTH-1:0], a_r[WIDTH-1]};
        diff    = shifted - {1'b0, b_r};
        prem_nx = diff[WIDTH] ? shifted : diff;
        a_nx    = {a_r[WIDTH-2:0], ~diff[WIDTH]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op_r        <= '0;
            dest_r      <= '0;
            a_r         <= '0;
            b_r         <= '0;
            mcand       <= '0;
            acc         <= '0;
            prem        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_wr_dest <= '0;
            reg_wr_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && op_ok) begin
                        op_r        <= op;
                        dest_r      <= dest;
                        a_r         <= src_a;
                        b_r         <= src_b;
                        mcand       <= {{WIDTH{1'b0}}, src_a};
                        acc         <= '0;
                        prem        <= '0;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        if (op != OP_MUL && src_b == '0) begin
                            // Divide by zero skips iteration: quotient all ones,
                            // remainder is the dividend.
                            state       <= WB;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            reg_wr_en   <= 1'b1;
                            reg_wr_dest <= dest;
                            reg_wr_data <= (op == OP_DIV) ? {WIDTH{1'b1}} : src_a;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (op_r == OP_MUL) begin
                        acc   <= acc_nx;
                        mcand <= mcand << 1;
                        b_r   <= b_r >> 1;
                    end else begin
                        prem <= prem_nx;
                        a_r  <= a_nx;
                    end
                    if (cnt == CW'(WIDTH-1)) begin
                        // Final iteration result goes straight to the write port.
                        state       <= WB;
                        done        <= 1'b1;
                        reg_wr_en   <= 1'b1;
                        reg_wr_dest <= dest_r;
                        if (op_r == OP_MUL)
                            reg_wr_data <= acc_nx[WIDTH-1:0];
                        else if (op_r == OP_DIV)
                            reg_wr_data <= a_nx;
                        else
                            reg_wr_data <= prem_nx[WIDTH-1:0];
                    end
                end
                WB: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    reg_wr_en   <= 1'b0;
                    reg_wr_dest <= '0;
                    reg_wr_data <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
